cam_serializer: RTL and testbench

CAM_SERIALIZER -- requirements
Module: cam_serializer

---
 rtl/cam_serializer.sv | 145 ++++++++++++++
 tb/tb_cam_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_serializer.sv
// cam_serializer: streams one frame of row-major pixels as a framed serial
// bit stream (start bit 1, IMG_W*IMG_H pixels MSB first, stop bit 0) with a
// divided bit clock. Pixels arrive through a one-entry holding register.
module cam_serializer #(
    parameter int IMG_W   = 26,
    parameter int IMG_H   = 26,
    parameter int PIX_W   = 8,
    parameter int CLK_DIV = 426
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_start,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             cam_data,
    output logic             cam_clk,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV - 1) + 1 : 1;
    localparam int BIT_W  = (PIX_W > 2) ? $clog2(PIX_W - 1) + 1 : 1;
    localparam int PIX_CW = (NPIX > 2) ? $clog2(NPIX - 1) + 1 : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PIX_W - 1);
    localparam logic [PIX_CW-1:0] PIX_LAST = PIX_CW'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [PIX_CW-1:0]  pix_cnt;
    logic [PIX_W-1:0]   shreg;
    logic [PIX_W-1:0]   hold_reg;
    logic               hold_full;

    logic bit_end, last_bit, last_pix, load, xfer, abort, accept;

    assign bit_end  = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign last_pix = (pix_cnt == PIX_LAST);
    assign abort    = !en && (state != IDLE);
    assign accept   = en && frame_start && (state == IDLE);
    // A pixel's first bit begins on leaving START and at every pixel boundary
    // inside DATA except after the final pixel.
    assign load     = en && bit_end &&
                      ((state == START) ||
                       ((state == DATA) && last_bit && !last_pix));
    assign xfer     = en && pix_valid && !hold_full;
    assign pix_ready = !hold_full;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and line outputs; dropping en always returns to IDLE.
    always_comb begin
        state_nxt = state;
        cam_data  = 1'b0;
        cam_clk   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:  if (en && frame_start) state_nxt = START;
            START: begin
                if (bit_end) state_nxt = DATA;
                cam_data = 1'b1;
            end
            DATA: begin
                if (bit_end && last_bit && last_pix) state_nxt = STOP;
                cam_data = shreg[PIX_W-1];
            end
            STOP:  if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            busy    = 1'b1;
            cam_clk = (div_cnt >= DIV_HALF);
        end
        if (!en) state_nxt = IDLE;
    end

    // Bit-period, bit and pixel counters; zero whenever idle or leaving a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
        end else if (state == IDLE || state_nxt == IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
        end else begin
            div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
            if (state == DATA && bit_end) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    // Shift register: load a fresh pixel (zero on underrun) or shift MSB out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          shreg <= '0;
        else if (abort)                   shreg <= '0;
        else if (load)                    shreg <= hold_full ? hold_reg : '0;
        else if (state == DATA && bit_end) shreg <= shreg << 1;
    end

    // Holding register: a transfer only lands in an empty slot, so a load and
    // a transfer in the same cycle leave the new pixel waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (abort) begin
            hold_full <= 1'b0;
        end else if (xfer) begin
            hold_reg  <= pix_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Sticky underrun, cleared when the next frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     underrun <= 1'b0;
        else if (accept)             underrun <= 1'b0;
        else if (load && !hold_full) underrun <= 1'b1;
    end

    // Frame-complete pulse on the first IDLE cycle after a finished stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= en && (state == STOP) && bit_end;
    end
endmodule

// File: tb/tb_cam_serializer.sv
// Bench for cam_serializer: expected serial bits are queued when a frame is
// set up and popped as the bit clock rises; control scenarios are checked
// against cycle counts derived from the frame format.
module tb_cam_serializer;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          frame_start = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready, cam_data, cam_clk, busy, frame_done, underrun;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc = 0, start_cyc = 0, done_cnt = 0, xfer_cnt = 0;
    int d0, x0;
    logic exp_q[$];

    cam_serializer #(.IMG_W(2), .IMG_H(2), .PIX_W(PW), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cam_data(cam_data), .cam_clk(cam_clk), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (!rst && en && pix_valid && pix_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Receiver model: sample cam_data on each bit-clock rising edge.
    always @(posedge cam_clk) begin
        #1;
        chk("bit_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("cam_bit", 32'(cam_data), 32'(exp_q.pop_front()));
    end

    task automatic push_pix(input logic [PW-1:0] p);
        for (int i = PW - 1; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    task automatic push_frame(input logic [PW-1:0] a, b, c, d);
        exp_q.push_back(1'b1);
        push_pix(a); push_pix(b); push_pix(c); push_pix(d);
        exp_q.push_back(1'b0);
    endtask

    // Offer a pixel (valid stays high afterwards); return after it is taken.
    task automatic feed(input logic [PW-1:0] p);
        int n = 0;
        pix_data  = p;
        pix_valid = 1'b1;
        while (!pix_ready && n < 300) begin @(negedge clk); n++; end
        chk("feed_ready", 32'(pix_ready), 1);
        @(negedge clk);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_k(input int k);
        while (cyc - start_cyc < k) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 400) begin @(negedge clk); n++; end
        chk(tag, 32'(frame_done), 1);
    endtask

    initial begin
        // Reset values, applied without relying on a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(cam_data), 0);
        chk("rst_clk", 32'(cam_clk), 0);
        chk("rst_ready", 32'(pix_ready), 1);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_underrun", 32'(underrun), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame, pixels always available.
        push_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
        x0 = xfer_cnt; d0 = done_cnt;
        feed(8'hA5);
        start_frame();
        chk("t1_busy", 32'(busy), 1);
        feed(8'h3C); feed(8'hFF); feed(8'h01);
        pix_valid = 1'b0;
        wait_done("t1_done_seen");
        chk("t1_len", 32'(cyc - start_cyc), 136);
        chk("t1_underrun", 32'(underrun), 0);
        chk("t1_xfers", 32'(xfer_cnt - x0), 4);
        @(negedge clk);
        chk("t1_done_once", 32'(done_cnt - d0), 1);
        chk("t1_q_empty", 32'(exp_q.size()), 0);

        // Pixel 2 withheld: shifted as zero, underrun, same frame length.
        push_frame(8'hA5, 8'h3C, 8'h00, 8'h01);
        feed(8'hA5);
        start_frame();
        feed(8'h3C);
        pix_valid = 1'b0;
        begin
            int n = 0;
            while (!underrun && n < 200) begin @(negedge clk); n++; end
        end
        chk("t2_underrun", 32'(underrun), 1);
        chk("t2_underrun_at", 32'(cyc - start_cyc), 68);
        feed(8'h01);
        pix_valid = 1'b0;
        wait_done("t2_done_seen");
        chk("t2_len", 32'(cyc - start_cyc), 136);
        chk("t2_underrun_sticky", 32'(underrun), 1);
        @(negedge clk);
        chk("t2_q_empty", 32'(exp_q.size()), 0);

        // en dropped during pixel 1 (its second bit).
        exp_q.push_back(1'b1);
        push_pix(8'hA5);
        exp_q.push_back(1'b0);
        feed(8'hA5);
        start_frame();
        chk("t3_underrun_clr", 32'(underrun), 0);
        feed(8'h3C);
        pix_data = 8'hFF;                 // valid stays high, taken after 3C loads
        d0 = done_cnt;
        wait_k(41);
        en = 1'b0;
        @(negedge clk);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_data", 32'(cam_data), 0);
        chk("t3_clk", 32'(cam_clk), 0);
        chk("t3_ready", 32'(pix_ready), 1);
        chk("t3_no_done", 32'(frame_done), 0);
        pix_valid = 1'b0;
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3_done_cnt", 32'(done_cnt - d0), 0);
        chk("t3_q_empty", 32'(exp_q.size()), 0);

        // Reset mid-frame, no pixel supplied so underrun is set beforehand.
        exp_q.push_back(1'b1);
        repeat (4) exp_q.push_back(1'b0);
        d0 = done_cnt;
        start_frame();
        wait_k(20);
        chk("t4_underrun_pre", 32'(underrun), 1);
        chk("t4_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_data", 32'(cam_data), 0);
        chk("t4_clk", 32'(cam_clk), 0);
        chk("t4_underrun", 32'(underrun), 0);
        chk("t4_ready", 32'(pix_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - d0), 0);
        chk("t4_q_empty", 32'(exp_q.size()), 0);

        // frame_start during DATA ignored; valid held high throughout.
        push_frame(8'h5A, 8'hC3, 8'h0F, 8'h80);
        x0 = xfer_cnt; d0 = done_cnt;
        feed(8'h5A);
        start_frame();
        feed(8'hC3); feed(8'h0F);
        wait_k(50);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        feed(8'h80);
        pix_data = 8'h77;                 // one more pixel fills the freed slot
        wait_done("t5_done_seen");
        chk("t5_len", 32'(cyc - start_cyc), 136);
        repeat (20) @(negedge clk);
        chk("t5_done_once", 32'(done_cnt - d0), 1);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_xfers", 32'(xfer_cnt - x0), 5);
        chk("t5_slot_full", 32'(pix_ready), 0);
        chk("t5_q_empty", 32'(exp_q.size()), 0);
        pix_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
